sync_fifo_param: RTL and testbench

//   Single-clock, parametrised-width/depth FIFO for intra-domain buffering.

---
 rtl/sync_fifo_param_if.sv | 45 ++++
 rtl/sync_fifo_param.sv | 122 ++++++++++++
 tb/tb_sync_fifo_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
//   Handshake/status bundle for sync_fifo_param.
//   master : producer/consumer side (drives winc/wdata/rinc/clr_err)
//   slave  : FIFO side (drives data, flags, occupancy and sticky errors)
//   Signals:
//     winc, wdata         write request and data
//     wfull               FIFO full
//     rinc                read request / pop
//     rdata, rvalid       read data and its valid qualifier
//     rempty              FIFO empty
//     afull, aempty       programmable almost-full / almost-empty
//     count               occupancy, 0..DEPTH
//     ovf, udf, clr_err   sticky overflow / underflow and their clear
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic             afull;
    logic             aempty;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;
    logic             clr_err;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  wfull, rdata, rvalid, rempty, afull, aempty, count, ovf, udf
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output wfull, rdata, rvalid, rempty, afull, aempty, count, ovf, udf
    );
endinterface

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty flags, sticky overflow/underflow and optional
//   first-word-fall-through read mode.
//   Ports:
//     clk   single clock, all logic on posedge
//     rst   synchronous reset, active-high
//     bus   sync_fifo_param_if.slave (write/read handshake, flags, errors)
//   Parameters: WIDTH, DEPTH (power of 2, >=4), AFULL_TH, AEMPTY_TH.
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through;
//   otherwise reads have a registered 1-cycle latency.
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_q;
    logic             udf_q;

    // Flags decode straight from the registered count, so they always
    // describe the state left by the previous edge.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_acc = bus.winc && !full;
    assign rd_acc = bus.rinc && !empty;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + AW'(1);
            if (rd_acc) rptr <= rptr + AW'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // define which entries are live, and an unreset array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= bus.wdata;
    end

    // Sticky errors: a rejected request sets the flag and takes priority
    // over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.winc && full)      ovf_q <= 1'b1;
            else if (bus.clr_err)      ovf_q <= 1'b0;
            if (bus.rinc && empty)     udf_q <= 1'b1;
            else if (bus.clr_err)      udf_q <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally; rinc pops what is shown.
    assign bus.rdata  = mem[rptr];
    assign bus.rvalid = !empty;
`else
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // Registered read: the popped word appears the cycle after rinc and is
    // held until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem[rptr];
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`endif

    assign bus.wfull  = full;
    assign bus.rempty = empty;
    assign bus.afull  = (count_q >= CW'(AFULL_TH));
    assign bus.aempty = (count_q <= CW'(AEMPTY_TH));
    assign bus.count  = count_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Directed self-checking bench for sync_fifo_param (WIDTH=16, DEPTH=64,
//   AFULL_TH=60, AEMPTY_TH=4). Works in both read modes; define
//   SYNC_FIFO_FWFT_EN for both RTL and bench to exercise fall-through.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [$];

    sync_fifo_param_if #(.WIDTH(16), .DEPTH(64)) bus ();

    sync_fifo_param #(
        .WIDTH(16), .DEPTH(64), .AFULL_TH(60), .AEMPTY_TH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] d);
        bus.winc  = 1'b1;
        bus.wdata = d;
        tick();
        bus.winc  = 1'b0;
        model.push_back(d);
    endtask

    // One pop cycle; returns the word the read delivers in the current mode.
    task automatic step_read(output logic [15:0] d, output logic v);
        bus.rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        d = bus.rdata;
        v = bus.rvalid;
        tick();
`else
        tick();
        d = bus.rdata;
        v = bus.rvalid;
`endif
        bus.rinc = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%b exp=1", bus.rempty); end
        checks++; if (bus.aempty !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b exp=1", bus.aempty); end
        checks++; if (bus.count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.wfull !== 1'b0) begin failures++; $display("FAIL reset_wfull got=%b exp=0", bus.wfull); end
        checks++; if (bus.afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", bus.afull); end
        checks++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", bus.ovf, bus.udf); end
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", bus.rdata); end
`endif
    endtask

    task automatic test_fill_drain();
        logic [15:0] d;
        logic        v;
        for (int i = 0; i < 64; i++) begin
            checks++; if (bus.count !== 7'(i)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i); end
            checks++; if (bus.afull !== (i >= 60)) begin failures++; $display("FAIL fill_afull count=%0d got=%b exp=%b", i, bus.afull, (i >= 60)); end
            checks++; if (bus.aempty !== (i <= 4)) begin failures++; $display("FAIL fill_aempty count=%0d got=%b exp=%b", i, bus.aempty, (i <= 4)); end
            write_word(16'(i));
        end
        checks++; if (bus.wfull !== 1'b1) begin failures++; $display("FAIL full_wfull got=%b exp=1", bus.wfull); end
        checks++; if (bus.count !== 7'd64) begin failures++; $display("FAIL full_count got=%0d exp=64", bus.count); end
        checks++; if (bus.afull !== 1'b1) begin failures++; $display("FAIL full_afull got=%b exp=1", bus.afull); end
        for (int i = 0; i < 64; i++) begin
            step_read(d, v);
            void'(model.pop_front());
            checks++; if (d !== 16'(i) || v !== 1'b1) begin failures++; $display("FAIL drain_data idx=%0d got=%h/%b exp=%h/1", i, d, v, 16'(i)); end
            checks++; if (bus.count !== 7'(63 - i)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", bus.count, 63 - i); end
        end
        tick();
        checks++; if (bus.rempty !== 1'b1 || bus.rvalid !== 1'b0) begin failures++; $display("FAIL drain_idle got=%b/%b exp=1/0", bus.rempty, bus.rvalid); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (bus.rdata !== 16'h003F) begin failures++; $display("FAIL rdata_hold got=%h exp=003f", bus.rdata); end
`endif
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic [15:0] exp_d;
        logic        v;
        for (int i = 0; i < 64; i++) write_word(16'h0100 + 16'(i));
        bus.winc  = 1'b1;
        bus.wdata = 16'hDEAD;
        tick();
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.ovf); end
        checks++; if (bus.count !== 7'd64) begin failures++; $display("FAIL ovf_count got=%0d exp=64", bus.count); end
        bus.clr_err = 1'b1;
        tick();
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", bus.ovf); end
        bus.winc = 1'b0;
        tick();
        bus.clr_err = 1'b0;
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", bus.ovf); end
        for (int i = 0; i < 64; i++) begin
            step_read(d, v);
            exp_d = model.pop_front();
            checks++; if (d !== exp_d) begin failures++; $display("FAIL ovf_drain idx=%0d got=%h exp=%h", i, d, exp_d); end
        end
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", bus.rempty); end
    endtask

    task automatic test_underflow();
        logic [15:0] d;
        logic [15:0] exp_d;
        logic        v;
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        checks++; if (bus.udf !== 1'b1) begin failures++; $display("FAIL udf_set got=%b exp=1", bus.udf); end
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL udf_rvalid got=%b exp=0", bus.rvalid); end
        checks++; if (bus.count !== 7'd0) begin failures++; $display("FAIL udf_count got=%0d exp=0", bus.count); end
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        checks++; if (bus.udf !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", bus.udf); end
        // Write and read together while empty: only the write is taken.
        bus.winc  = 1'b1;
        bus.wdata = 16'h0055;
        bus.rinc  = 1'b1;
        tick();
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        model.push_back(16'h0055);
        checks++; if (bus.count !== 7'd1) begin failures++; $display("FAIL wr_rd_empty_count got=%0d exp=1", bus.count); end
        checks++; if (bus.udf !== 1'b1) begin failures++; $display("FAIL wr_rd_empty_udf got=%b exp=1", bus.udf); end
        step_read(d, v);
        exp_d = model.pop_front();
        checks++; if (d !== exp_d || v !== 1'b1) begin failures++; $display("FAIL wr_rd_empty_data got=%h/%b exp=%h/1", d, v, exp_d); end
        // Write and read together while full: only the read is taken.
        for (int i = 0; i < 64; i++) write_word(16'h0400 + 16'(i));
        bus.winc  = 1'b1;
        bus.wdata = 16'hBAD1;
        step_read(d, v);
        bus.winc = 1'b0;
        exp_d = model.pop_front();
        checks++; if (d !== exp_d) begin failures++; $display("FAIL wr_rd_full_data got=%h exp=%h", d, exp_d); end
        checks++; if (bus.count !== 7'd63) begin failures++; $display("FAIL wr_rd_full_count got=%0d exp=63", bus.count); end
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL wr_rd_full_ovf got=%b exp=1", bus.ovf); end
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        for (int i = 0; i < 63; i++) begin
            step_read(d, v);
            exp_d = model.pop_front();
            checks++; if (d !== exp_d) begin failures++; $display("FAIL wr_rd_full_drain idx=%0d got=%h exp=%h", i, d, exp_d); end
        end
        checks++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0 || bus.rempty !== 1'b1) begin failures++; $display("FAIL udf_end got=%b%b%b exp=001", bus.ovf, bus.udf, bus.rempty); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] exp_d;
        logic        v;
        for (int i = 0; i < 10; i++) write_word(16'h0200 + 16'(i));
        for (int k = 0; k < 200; k++) begin
            bus.winc  = 1'b1;
            bus.wdata = 16'h0300 + 16'(k);
            step_read(d, v);
            model.push_back(16'h0300 + 16'(k));
            exp_d = model.pop_front();
            checks++; if (d !== exp_d || v !== 1'b1) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h/%b exp=%h/1", k, d, v, exp_d); end
            checks++; if (bus.count !== 7'd10) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=10", k, bus.count); end
            checks++; if ({bus.wfull, bus.rempty, bus.afull, bus.aempty, bus.ovf, bus.udf} !== 6'b0) begin
                failures++; $display("FAIL b2b_flags cyc=%0d got=%b exp=000000", k,
                                     {bus.wfull, bus.rempty, bus.afull, bus.aempty, bus.ovf, bus.udf});
            end
        end
        bus.winc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_read(d, v);
            exp_d = model.pop_front();
            checks++; if (d !== exp_d) begin failures++; $display("FAIL b2b_drain idx=%0d got=%h exp=%h", i, d, exp_d); end
        end
        checks++; if (bus.rempty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", bus.rempty); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        v;
        for (int i = 0; i < 37; i++) write_word(16'h0500 + 16'(i));
        checks++; if (bus.count !== 7'd37) begin failures++; $display("FAIL mid_count_pre got=%0d exp=37", bus.count); end
        bus.winc  = 1'b1;
        bus.wdata = 16'h0BAD;
        bus.rinc  = 1'b1;
        rst       = 1'b1;
        tick();
        rst      = 1'b0;
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        model.delete();
        checks++; if (bus.count !== 7'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.count); end
        checks++; if (bus.rempty !== 1'b1 || bus.rvalid !== 1'b0) begin failures++; $display("FAIL mid_flags got=%b/%b exp=1/0", bus.rempty, bus.rvalid); end
        write_word(16'hBEEF);
        checks++; if (bus.rempty !== 1'b0 || bus.count !== 7'd1) begin failures++; $display("FAIL mid_write got=%b/%0d exp=0/1", bus.rempty, bus.count); end
        step_read(d, v);
        void'(model.pop_front());
        checks++; if (d !== 16'hBEEF || v !== 1'b1) begin failures++; $display("FAIL mid_read got=%h/%b exp=beef/1", d, v); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.winc    = 1'b0;
        bus.wdata   = '0;
        bus.rinc    = 1'b0;
        bus.clr_err = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
